// File: rtl/wsc_wir_ctrl.sv
// -----------------------------------------------------------------------------
// wsc_wir_ctrl
//
// Wrapper Serial Control front-end. Holds the Wrapper Instruction Register
// (shift stage + update stage), decodes the active instruction into the
// control set that fans out to every WBR cell, owns the Wrapper Bypass
// register (WBY) and selects what drives the wrapper serial output.
//
// Ports
//   clk        wrapper clock (WRCK), all state on rising edge
//   arst       asynchronous active-low reset (WRSTN)
//   wsi        wrapper serial in
//   selectwir  1 = WIR path selected, 0 = data path (WBR/WBY)
//   shiftwr    shift strobe
//   capturewr  capture strobe
//   updatewr   update strobe
//   transferdr transfer strobe
//   wbr_so     serial out of the last WBR cell
//   wso        wrapper serial out
//   wbr_si     serial in to the first WBR cell (straight copy of wsi)
//   shift      WBR cell shift     (gated by decode, zero latency)
//   capture    WBR cell capture   (gated by decode, suppressed for PRELOAD)
//   transfer   WBR cell transfer  (gated by decode, zero latency)
//   update     WBR cell update    (gated by decode, zero latency)
//   mode       WBR cell mode, 1 = test        (registered)
//   safe       WBR cell safe                  (registered)
//   io_face    1 = outward (EXTEST/CLAMP)     (registered)
//   instr      currently active (updated) instruction, raw code
//
// WIR_W is the instruction width; it must be at least 3.
// -----------------------------------------------------------------------------
module wsc_wir_ctrl #(
  parameter int WIR_W = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wsi,
  input  logic             selectwir,
  input  logic             shiftwr,
  input  logic             capturewr,
  input  logic             updatewr,
  input  logic             transferdr,
  input  logic             wbr_so,
  output logic             wso,
  output logic             wbr_si,
  output logic             shift,
  output logic             capture,
  output logic             transfer,
  output logic             update,
  output logic             mode,
  output logic             safe,
  output logic             io_face,
  output logic [WIR_W-1:0] instr
);

  typedef enum logic [WIR_W-1:0] {
    WS_BYPASS  = WIR_W'(0),
    WS_EXTEST  = WIR_W'(1),
    WS_INTEST  = WIR_W'(2),
    WS_SAFE    = WIR_W'(3),
    WS_PRELOAD = WIR_W'(4),
    WS_CLAMP   = WIR_W'(5)
  } ws_instr_e;

  // Static cell controls carried as one bundle so they are loaded together.
  typedef struct packed {
    logic mode;
    logic safe;
    logic io_face;
  } static_ctrl_t;

  logic [WIR_W-1:0] wir_shift;
  logic [WIR_W-1:0] wir_upd;
  static_ctrl_t     static_q;
  logic             wby;
  logic             wbr_sel;

  // Codes outside the table fall through to the default and behave as BYPASS.
  function automatic static_ctrl_t static_of(input logic [WIR_W-1:0] code);
    static_ctrl_t s;
    s = '0;
    case (code)
      WS_EXTEST: s = '{mode: 1'b1, safe: 1'b0, io_face: 1'b1};
      WS_INTEST: s = '{mode: 1'b1, safe: 1'b0, io_face: 1'b0};
      WS_SAFE:   s = '{mode: 1'b1, safe: 1'b1, io_face: 1'b0};
      WS_CLAMP:  s = '{mode: 1'b1, safe: 1'b0, io_face: 1'b1};
      default:   s = '0;
    endcase
    return s;
  endfunction

  function automatic logic selects_wbr(input logic [WIR_W-1:0] code);
    return (code == WS_EXTEST) || (code == WS_INTEST) || (code == WS_PRELOAD);
  endfunction

  // ---------------------------------------------------------------------------
  // WIR shift and update stages. The update stage copies the pre-edge shift
  // stage, so an update in the same cycle as a shift/capture sees the old bits.
  // The static controls are loaded on the same edge as the update stage, which
  // keeps them aligned with instr and glitch-free at the cell boundary.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst) begin
    // NOTE: every control/state flop is cleared by the async reset so that no
    // partial instruction or stale test mode survives it.
    if (!arst) begin
      wir_shift <= '0;
      wir_upd   <= WS_BYPASS;
      static_q  <= '0;
    end else if (selectwir) begin
      // NOTE: non-blocking assignments here are what make the update stage
      // pick up the shift-stage value from before this edge.
      if (capturewr) begin
        wir_shift <= WIR_W'(1);
      end else if (shiftwr) begin
        wir_shift <= {wsi, wir_shift[WIR_W-1:1]};
      end
      if (updatewr) begin
        wir_upd  <= wir_shift;
        static_q <= static_of(wir_shift);
      end
    end
  end

  // Decode of the active instruction; the update stage is a register, so this
  // only moves on a clock edge.
  assign wbr_sel = selects_wbr(wir_upd);

  // ---------------------------------------------------------------------------
  // Wrapper bypass register: one bit, live only when the data path is selected
  // and the active instruction does not route through the WBR.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wby <= 1'b0;
    end else if (!selectwir && !wbr_sel) begin
      if (capturewr) begin
        wby <= 1'b0;
      end else if (shiftwr) begin
        wby <= wsi;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cell strobes. The ~selectwir term is part of every AND, so no strobe can
  // rise while the WIR path is selected, whatever the strobe inputs do.
  // ---------------------------------------------------------------------------
  assign shift    = shiftwr    & ~selectwir & wbr_sel;
  assign capture  = capturewr  & ~selectwir & wbr_sel & (wir_upd != WS_PRELOAD);
  assign update   = updatewr   & ~selectwir & wbr_sel;
  assign transfer = transferdr & ~selectwir & wbr_sel;

  assign mode    = static_q.mode;
  assign safe    = static_q.safe;
  assign io_face = static_q.io_face;
  assign instr   = wir_upd;
  assign wbr_si  = wsi;

  always_comb begin
    wso = wby;
    if (selectwir) begin
      wso = wir_shift[0];
    end else if (wbr_sel) begin
      wso = wbr_so;
    end
  end

endmodule
